execute_memory_stage: RTL and testbench
=======================================

Name: execute_memory_stage

Overview:
- Back end of the 5-stage MIPS pipeline. Consumes the decode-stage outputs (A, B, RD, ALUctr, DX_lwFlag, DX_swFlag) and performs the ALU operation and the data-memory access.
- Returns the writeback pair MW_RD / MW_ALUout, which the decode stage writes into its register file.
- Contains the DX->XM and XM->MW pipeline registers and the word-addressed data memory.

Parameters:
- DM_DEPTH, 256, data-memory depth in 32-bit words (power of two).
- DM_AW, 8, word-address width (log2 DM_DEPTH).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-low reset (0 = reset, sampled on posedge clk).
- A  in  32  operand A (rs contents).
- B  in  32  operand B (rt contents for R-type; zero-extended imm for lw/sw).
- RD  in  5  destination register; 0 = no writeback.
- ALUctr  in  3  ALU op: 0 add, 1 sub, 2 slt.
- DX_lwFlag  in  1  load in X stage.
- DX_swFlag  in  1  store in X stage.
- DX_swData  in  32  store data (rt contents), valid with DX_swFlag.
- MW_RD  out  5  writeback register index.
- MW_ALUout  out  32  writeback data (ALU result or load data).

Behaviour:
- Reset (rst==0 at posedge): MW_RD=0, MW_ALUout=0, all XM registers =0 (XM_RD=0, XM_res=0, XM_lw=0, XM_sw=0, XM_sd=0). Memory contents are not cleared. An in-flight store in XM is dropped (no memory write during reset).
- X stage (combinational on inputs, registered at edge 1):
  - ALUctr 0: res = A+B (mod 2^32).
  - ALUctr 1: res = A-B (mod 2^32).
  - ALUctr 2: res = {31'b0, signed(A)<signed(B)}.
  - ALUctr 3..7: res = 0.
  - Register into XM: res, RD, lw, sw, DX_swData.
  - If DX_swFlag=1: XM_RD is forced to 0, so a store never writes back.
  - If both flags are 1: treated as a store; lw is ignored.
- M stage (between edge 1 and edge 2):
  - Word address = XM_res[DM_AW+1:2]. Low 2 bits are ignored (no misalignment fault). Upper bits are ignored, so addresses wrap modulo DM_DEPTH.
  - XM_sw=1: mem[addr] <= XM_sd at edge 2. MW_RD <= 0, MW_ALUout <= XM_res.
  - XM_lw=1: MW_ALUout <= mem[addr] (asynchronous read of current contents). MW_RD <= XM_RD.
  - Otherwise: MW_ALUout <= XM_res, MW_RD <= XM_RD.
- Latency: 2 clocks from inputs to MW outputs; the register file updates at the third edge.
- Back-to-back sw then lw to the same address: the store writes at its edge 2, which is the lw's edge 1, so the lw reads the new data. No extra logic is needed.
- Same-edge read/write: not possible. Only one instruction occupies M per cycle.
- Bubble: RD=0 with both flags 0 produces MW_RD=0, no memory write, MW_ALUout = ALU result (ignored downstream).
- No stall/flush inputs. Every cycle advances the pipeline.

Optional Feature:
- Macro: EXMEM_OVF_TRAP_EN.
- Defined:
  - Adds output port XM_ovf (1 bit, reset 0), registered at edge 1.
  - XM_ovf = signed overflow of add (ALUctr 0, non-load/store) or sub (ALUctr 1).
  - On overflow, that instruction's MW_RD is forced to 0 (writeback suppressed). MW_ALUout still carries the wrapped result.
  - lw/sw address adds never flag.
- Undefined: the port is absent and overflow wraps silently with normal writeback.

Decomposition:
- Shared package mips_pkg holds:
  - ALUctr encodings ALU_ADD=3'd0, ALU_SUB=3'd1, ALU_SLT=3'd2.
  - Opcode/funct constants (OP_RTYPE=0, OP_LW=35, OP_SW=43, OP_BEQ=4, OP_J=2, F_ADD=32, F_SUB=34, F_SLT=42).
  - Data width 32, register-index width 5.
  - The decode stage imports the same package.
- One sub-module: data_memory. Parameters DM_DEPTH/DM_AW; ports clk, we, addr, wdata, rdata; asynchronous read, synchronous write.
- ALU stays inline.

Test Plan:
1. Hold rst=0 for 2 edges with garbage inputs -> MW_RD=0, MW_ALUout=0; no memory write observed. Release rst=1 -> normal operation.
2. A=5, B=7, RD=3, ALUctr=0 -> after 2 edges MW_RD=3, MW_ALUout=12. Then ALUctr=1 -> MW_ALUout=0xFFFFFFFE. Then ALUctr=2, A=0xFFFFFFFF, B=1 -> MW_ALUout=1.
3. sw: A=0x10, B=0x4, DX_swData=0xDEADBEEF, RD=9 -> MW_RD=0, mem[5]=0xDEADBEEF. Next cycle lw: A=0x14, B=0, RD=8 -> MW_RD=8, MW_ALUout=0xDEADBEEF.
4. Wrap/misalign: sw at address 0x404+1 (DM_DEPTH=256) with data 0x1234 -> mem[1] written. lw from 0x4 returns 0x1234.
5. Reset asserted on the edge a sw sits in XM -> target word unchanged; MW_RD=0 after release.
6. With EXMEM_OVF_TRAP_EN: A=0x7FFFFFFF, B=1, RD=4, add -> XM_ovf=1, MW_RD=0, MW_ALUout=0x80000000. Without the macro -> MW_RD=4, same MW_ALUout.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU control encodings, opcode/funct
// constants and datapath widths. The decode stage imports this package too.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // ALU control encodings driven by decode onto ALUctr
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_SLT = 3'd2;

    // Instruction opcode field values
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd2;

    // R-type funct field values
    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_SLT = 6'd42;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: asynchronous read, synchronous write.
// Contents are deliberately not reset.
module data_memory
    import mips_pkg::*;
#(
    parameter int DM_DEPTH = 256,
    parameter int DM_AW    = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [DM_AW-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DM_DEPTH];

    // Store the write word at the clock edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule

// File: rtl/execute_memory_stage.sv
// Execute + memory back end of the 5-stage MIPS pipeline.
// Holds the DX->XM and XM->MW registers, the inline ALU and the data memory.
// Optional macro EXMEM_OVF_TRAP_EN adds the XM_ovf output and suppresses
// writeback of add/sub results that overflow.
module execute_memory_stage
    import mips_pkg::*;
#(
    parameter int DM_DEPTH = 256,
    parameter int DM_AW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [REG_W-1:0]  RD,
    input  logic [2:0]        ALUctr,
    input  logic              DX_lwFlag,
    input  logic              DX_swFlag,
    input  logic [DATA_W-1:0] DX_swData,
    output logic [REG_W-1:0]  MW_RD,
    output logic [DATA_W-1:0] MW_ALUout
`ifdef EXMEM_OVF_TRAP_EN
    ,
    output logic              XM_ovf
`endif
);

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_res;
    logic              w_is_sw;
    logic              w_is_lw;
    logic              w_suppress_wb;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_rdata;

    logic [REG_W-1:0]  r_xm_rd;
    logic [DATA_W-1:0] r_xm_res;
    logic              r_xm_lw;
    logic              r_xm_sw;
    logic [DATA_W-1:0] r_xm_sd;

    assign w_sum   = A + B;
    assign w_diff  = A - B;
    // A store wins when both flags are raised
    assign w_is_sw = DX_swFlag;
    assign w_is_lw = DX_lwFlag & ~DX_swFlag;

    // ALU result selection
    always_comb begin
        w_res = '0;
        unique case (ALUctr)
            ALU_ADD: w_res = w_sum;
            ALU_SUB: w_res = w_diff;
            ALU_SLT: w_res = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
            default: w_res = '0;
        endcase
    end

`ifdef EXMEM_OVF_TRAP_EN
    logic w_ovf;
    logic r_xm_ovf;

    // Signed overflow of arithmetic ops; memory address adds never flag
    always_comb begin
        w_ovf = 1'b0;
        if (!DX_lwFlag && !DX_swFlag) begin
            if (ALUctr == ALU_ADD) begin
                w_ovf = (A[DATA_W-1] == B[DATA_W-1]) && (w_sum[DATA_W-1] != A[DATA_W-1]);
            end else if (ALUctr == ALU_SUB) begin
                w_ovf = (A[DATA_W-1] != B[DATA_W-1]) && (w_diff[DATA_W-1] != A[DATA_W-1]);
            end
        end
    end

    // Overflow flag travels with its instruction into XM
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_xm_ovf <= 1'b0;
        end else begin
            r_xm_ovf <= w_ovf;
        end
    end

    assign XM_ovf        = r_xm_ovf;
    assign w_suppress_wb = r_xm_ovf;
`else
    assign w_suppress_wb = 1'b0;
`endif

    // DX->XM pipeline register; stores never write back
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_xm_rd  <= '0;
            r_xm_res <= '0;
            r_xm_lw  <= 1'b0;
            r_xm_sw  <= 1'b0;
            r_xm_sd  <= '0;
        end else begin
            r_xm_rd  <= w_is_sw ? '0 : RD;
            r_xm_res <= w_res;
            r_xm_lw  <= w_is_lw;
            r_xm_sw  <= w_is_sw;
            r_xm_sd  <= DX_swData;
        end
    end

    // A store sitting in XM during reset is dropped
    assign w_mem_we = r_xm_sw & rst;

    data_memory #(
        .DM_DEPTH (DM_DEPTH),
        .DM_AW    (DM_AW)
    ) u_dmem (
        .clk   (clk),
        .we    (w_mem_we),
        .addr  (r_xm_res[DM_AW+1:2]),
        .wdata (r_xm_sd),
        .rdata (w_mem_rdata)
    );

    // XM->MW pipeline register: load data or ALU result, plus writeback index
    always_ff @(posedge clk) begin
        if (!rst) begin
            MW_RD     <= '0;
            MW_ALUout <= '0;
        end else if (r_xm_sw) begin
            MW_RD     <= '0;
            MW_ALUout <= r_xm_res;
        end else if (r_xm_lw) begin
            MW_RD     <= r_xm_rd;
            MW_ALUout <= w_mem_rdata;
        end else begin
            MW_RD     <= w_suppress_wb ? '0 : r_xm_rd;
            MW_ALUout <= r_xm_res;
        end
    end

endmodule

// File: tb/tb_execute_memory_stage.sv
// Bench for execute_memory_stage: reset checks, a table of directed vectors,
// hand-written reset/store/overflow sequences and randomized instructions
// checked against a program-order behavioural model.
module tb_execute_memory_stage;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  RD;
    logic [2:0]  ALUctr;
    logic        DX_lwFlag;
    logic        DX_swFlag;
    logic [31:0] DX_swData;
    logic [4:0]  MW_RD;
    logic [31:0] MW_ALUout;
`ifdef EXMEM_OVF_TRAP_EN
    logic        XM_ovf;
`endif

    execute_memory_stage dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .RD        (RD),
        .ALUctr    (ALUctr),
        .DX_lwFlag (DX_lwFlag),
        .DX_swFlag (DX_swFlag),
        .DX_swData (DX_swData),
        .MW_RD     (MW_RD),
        .MW_ALUout (MW_ALUout)
`ifdef EXMEM_OVF_TRAP_EN
        ,
        .XM_ovf    (XM_ovf)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected entry: [37] data valid, [36:32] MW_RD, [31:0] MW_ALUout
    logic [37:0] exp_q[$];
    // Model memory: only words the program has stored are known
    logic [31:0] mdl_mem [int];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [2:0]  ctr;
        logic        lw;
        logic        sw;
        logic [4:0]  exp_rd;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: architectural effect of one instruction in program order
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] sd, input logic [4:0] rd,
                                      input logic [2:0] ctr, input logic lw, input logic sw,
                                      output logic [37:0] e, output logic ovf);
        longint sa;
        longint sb;
        longint wide;
        logic [31:0] res;
        int word;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (ctr)
            3'd0:    wide = sa + sb;
            3'd1:    wide = sa - sb;
            3'd2:    wide = (sa < sb) ? 64'd1 : 64'd0;
            default: wide = 0;
        endcase
        res  = wide[31:0];
        ovf  = !lw && !sw && (ctr <= 3'd1) && (wide != longint'($signed(res)));
        word = int'(res / 4) % 256;
        if (sw) begin
            mdl_mem[word] = sd;
            e = {1'b1, 5'd0, res};
        end else if (lw) begin
            if (mdl_mem.exists(word)) e = {1'b1, rd, mdl_mem[word]};
            else                      e = {1'b0, rd, 32'h0};
        end else begin
`ifdef EXMEM_OVF_TRAP_EN
            e = {1'b1, (ovf ? 5'd0 : rd), res};
`else
            e = {1'b1, rd, res};
`endif
        end
    endfunction

    // Drive one instruction at a negedge; compare the one issued a cycle earlier
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                         input logic [4:0] rd, input logic [2:0] ctr, input logic lw,
                         input logic sw, input logic [37:0] e, input logic e_ovf);
        logic [37:0] old;
        A = a; B = b; DX_swData = sd; RD = rd; ALUctr = ctr;
        DX_lwFlag = lw; DX_swFlag = sw;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
`ifdef EXMEM_OVF_TRAP_EN
        check("xm_ovf", {31'd0, XM_ovf}, {31'd0, e_ovf});
`else
        if (e_ovf === 1'bx) $display("note: unknown overflow expectation");
`endif
        if (exp_q.size() == 2) begin
            old = exp_q.pop_front();
            check("mw_rd", {27'd0, MW_RD}, {27'd0, old[36:32]});
            if (old[37]) check("mw_aluout", MW_ALUout, old[31:0]);
        end
    endtask

    task automatic modeled(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                           input logic [4:0] rd, input logic [2:0] ctr, input logic lw,
                           input logic sw);
        logic [37:0] e;
        logic ovf;
        ref_model(a, b, sd, rd, ctr, lw, sw, e, ovf);
        issue(a, b, sd, rd, ctr, lw, sw, e, ovf);
    endtask

    task automatic bubble();
        modeled(32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 1'b0, 1'b0);
    endtask

    // Hold reset for two edges with garbage inputs; pipeline must read zero
    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            A = $urandom; B = $urandom; DX_swData = $urandom;
            RD = 5'($urandom_range(1, 31)); ALUctr = 3'($urandom_range(0, 7));
            DX_lwFlag = 1'b1; DX_swFlag = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("rst_mw_rd", {27'd0, MW_RD}, 32'd0);
            check("rst_mw_aluout", MW_ALUout, 32'd0);
        end
        exp_q.delete();
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rlw;
        logic        rsw;

        // Directed vectors: inputs and required writeback two edges later
        vecs[0]  = '{32'd5,        32'd7,        32'd0,        5'd3,  3'd0, 1'b0, 1'b0, 5'd3,  32'd12};
        vecs[1]  = '{32'd5,        32'd7,        32'd0,        5'd3,  3'd1, 1'b0, 1'b0, 5'd3,  32'hFFFF_FFFE};
        vecs[2]  = '{32'hFFFF_FFFF, 32'd1,       32'd0,        5'd3,  3'd2, 1'b0, 1'b0, 5'd3,  32'd1};
        vecs[3]  = '{32'd1,        32'hFFFF_FFFF, 32'd0,       5'd3,  3'd2, 1'b0, 1'b0, 5'd3,  32'd0};
        vecs[4]  = '{32'd9,        32'd9,        32'd0,        5'd3,  3'd5, 1'b0, 1'b0, 5'd3,  32'd0};
        vecs[5]  = '{32'h10,       32'h4,        32'hDEAD_BEEF, 5'd9, 3'd0, 1'b0, 1'b1, 5'd0,  32'h14};
        vecs[6]  = '{32'h14,       32'h0,        32'd0,        5'd8,  3'd0, 1'b1, 1'b0, 5'd8,  32'hDEAD_BEEF};
        vecs[7]  = '{32'h404,      32'h1,        32'h1234,     5'd0,  3'd0, 1'b0, 1'b1, 5'd0,  32'h405};
        vecs[8]  = '{32'h4,        32'h0,        32'd0,        5'd7,  3'd0, 1'b1, 1'b0, 5'd7,  32'h1234};
        vecs[9]  = '{32'h20,       32'h0,        32'hCAFE_F00D, 5'd6, 3'd0, 1'b1, 1'b1, 5'd0,  32'h20};
        vecs[10] = '{32'h22,       32'h1,        32'd0,        5'd1,  3'd0, 1'b1, 1'b0, 5'd1,  32'hCAFE_F00D};
        vecs[11] = '{32'd3,        32'd4,        32'd0,        5'd0,  3'd0, 1'b0, 1'b0, 5'd0,  32'd7};
        vecs[12] = '{32'd0,        32'd1,        32'd0,        5'd31, 3'd1, 1'b0, 1'b0, 5'd31, 32'hFFFF_FFFF};

        rst = 1'b0;
        A = '0; B = '0; RD = '0; ALUctr = '0;
        DX_lwFlag = 1'b0; DX_swFlag = 1'b0; DX_swData = '0;
        @(negedge clk);
        do_reset();

        // Directed table; the model only tracks the stores for later loads
        for (int i = 0; i < 13; i++) begin
            logic [37:0] junk;
            logic junk_ovf;
            ref_model(vecs[i].a, vecs[i].b, vecs[i].sd, vecs[i].rd, vecs[i].ctr,
                      vecs[i].lw, vecs[i].sw, junk, junk_ovf);
            issue(vecs[i].a, vecs[i].b, vecs[i].sd, vecs[i].rd, vecs[i].ctr,
                  vecs[i].lw, vecs[i].sw, {1'b1, vecs[i].exp_rd, vecs[i].exp_out}, 1'b0);
        end
        bubble();

        // Overflowing add: writeback suppressed only when trapping is built in
`ifdef EXMEM_OVF_TRAP_EN
        issue(32'h7FFF_FFFF, 32'd1, 32'd0, 5'd4, 3'd0, 1'b0, 1'b0, {1'b1, 5'd0, 32'h8000_0000}, 1'b1);
        issue(32'h8000_0000, 32'd1, 32'd0, 5'd5, 3'd1, 1'b0, 1'b0, {1'b1, 5'd0, 32'h7FFF_FFFF}, 1'b1);
`else
        issue(32'h7FFF_FFFF, 32'd1, 32'd0, 5'd4, 3'd0, 1'b0, 1'b0, {1'b1, 5'd4, 32'h8000_0000}, 1'b1);
        issue(32'h8000_0000, 32'd1, 32'd0, 5'd5, 3'd1, 1'b0, 1'b0, {1'b1, 5'd5, 32'h7FFF_FFFF}, 1'b1);
`endif
        // Overflowing address add on a load is not an arithmetic overflow
        issue(32'h7FFF_FFFF, 32'd5, 32'd0, 5'd6, 3'd0, 1'b1, 1'b0, {1'b1, 5'd6, 32'h1234}, 1'b0);
        bubble();

        // Store a known word, then reset while a second store sits in XM
        modeled(32'h30, 32'h0, 32'h5555_AAAA, 5'd0, 3'd0, 1'b0, 1'b1);
        bubble();
        issue(32'h30, 32'h0, 32'h0BAD_0BAD, 5'd12, 3'd0, 1'b0, 1'b1, {1'b1, 5'd0, 32'h30}, 1'b0);
        do_reset();
        issue(32'h30, 32'h0, 32'd0, 5'd2, 3'd0, 1'b1, 1'b0, {1'b1, 5'd2, 32'h5555_AAAA}, 1'b0);
        bubble();
        bubble();

        // Randomized instruction stream against the model
        for (int i = 0; i < 400; i++) begin
            rsw = ($urandom_range(0, 99) < 25);
            rlw = ($urandom_range(0, 99) < 30);
            if (rsw || rlw) begin
                ra = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
                rb = 32'($urandom_range(0, 7));
            end else if ($urandom_range(0, 3) == 0) begin
                ra = {$urandom_range(0, 1) == 1 ? 2'b10 : 2'b01, 30'($urandom)};
                rb = {$urandom_range(0, 1) == 1 ? 2'b10 : 2'b01, 30'($urandom)};
            end else begin
                ra = $urandom;
                rb = $urandom;
            end
            modeled(ra, rb, $urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), rlw, rsw);
        end
        bubble();
        bubble();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        n_errors++;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
